// File: rtl/alu_dispatch_stage.sv
// Issue stage in front of the ALU element: accepts one op, runs the
// element's reset/release/completed protocol, and hands the result to writeback.
//
// Ports:
//   clk, reset            : clock, async active-high reset
//   in_valid/in_ready     : upstream op handshake
//   in_inst_num..in_dest  : decoded op fields
//   elem_*                : element start (elem_reset), operands, completed/out
//   wb_valid/wb_ready     : writeback handshake
//   wb_dest, wb_data      : result destination and value
//   wb_illegal/wb_timeout : result status flags
//   busy                  : an op is in flight
module alu_dispatch_stage #(
  parameter int START_CYCLES   = 2,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [5:0]  in_inst_num,
  input  logic [31:0] in_const16_x,
  input  logic [4:0]  in_shift5,
  input  logic [31:0] in_rs,
  input  logic [31:0] in_rt,
  input  logic [4:0]  in_dest,
  output logic        elem_reset,
  output logic [5:0]  elem_inst_num,
  output logic [31:0] elem_const16_x,
  output logic [4:0]  elem_shift5,
  output logic [31:0] elem_rs,
  output logic [31:0] elem_rt,
  input  logic        elem_completed,
  input  logic [31:0] elem_out,
  output logic        wb_valid,
  input  logic        wb_ready,
  output logic [4:0]  wb_dest,
  output logic [31:0] wb_data,
  output logic        wb_illegal,
  output logic        wb_timeout,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE,
    START,
    WAIT,
    RESULT
  } state_t;

  localparam int CMAX = (START_CYCLES > TIMEOUT_CYCLES)
                      ? START_CYCLES : TIMEOUT_CYCLES;
  localparam int CW = $clog2(CMAX + 1);
  localparam logic [CW-1:0] START_LAST = CW'(START_CYCLES - 1);
  localparam logic [CW-1:0] TO_LAST    = CW'(TIMEOUT_CYCLES - 1);

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          legal;
  logic          accept;
  logic          cmpl;
  logic          tmo;
  logic          wb_fire;

  assign legal = (in_inst_num >= 6'd8  && in_inst_num <= 6'd18) ||
                 (in_inst_num >= 6'd20 && in_inst_num <= 6'd26);

  assign accept  = (state_q == IDLE) && in_valid;
  // Completion has priority over a timeout on the same edge.
  assign cmpl    = (state_q == WAIT) && elem_completed;
  assign tmo     = (state_q == WAIT) && !elem_completed && (cnt_q == TO_LAST);
  assign wb_fire = (state_q == RESULT) && wb_ready;

  assign in_ready   = (state_q == IDLE);
  assign busy       = (state_q != IDLE);
  assign elem_reset = (state_q != WAIT);
  assign wb_valid   = (state_q == RESULT);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          cnt_d   = '0;
          state_d = legal ? START : RESULT;
        end
      end
      START: begin
        if (cnt_q == START_LAST) begin
          cnt_d   = '0;
          state_d = WAIT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      WAIT: begin
        if (cmpl || tmo) begin
          state_d = RESULT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RESULT: begin
        if (wb_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      elem_inst_num  <= '0;
      elem_const16_x <= '0;
      elem_shift5    <= '0;
      elem_rs        <= '0;
      elem_rt        <= '0;
      wb_dest        <= '0;
      wb_data        <= '0;
      wb_illegal     <= 1'b0;
      wb_timeout     <= 1'b0;
    end else begin
      unique case (1'b1)
        accept: begin
          elem_inst_num  <= in_inst_num;
          elem_const16_x <= in_const16_x;
          elem_shift5    <= in_shift5;
          elem_rs        <= in_rs;
          elem_rt        <= in_rt;
          wb_dest        <= in_dest;
          if (!legal) begin
            wb_illegal <= 1'b1;
            wb_data    <= '0;
          end
        end
        cmpl: begin
          wb_data <= elem_out;
        end
        tmo: begin
          wb_timeout <= 1'b1;
          wb_data    <= '0;
        end
        wb_fire: begin
          wb_illegal <= 1'b0;
          wb_timeout <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_dispatch_stage.sv
// Directed bench for alu_dispatch_stage with a small behavioural ALU
// element (normal, never-completes, and completes-on-64th-cycle modes).
module tb_alu_dispatch_stage;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [5:0]  in_inst_num = '0;
  logic [31:0] in_const16_x = '0;
  logic [4:0]  in_shift5 = '0;
  logic [31:0] in_rs = '0;
  logic [31:0] in_rt = '0;
  logic [4:0]  in_dest = '0;
  logic        elem_reset;
  logic [5:0]  elem_inst_num;
  logic [31:0] elem_const16_x;
  logic [4:0]  elem_shift5;
  logic [31:0] elem_rs;
  logic [31:0] elem_rt;
  logic        elem_completed;
  logic [31:0] elem_out;
  logic        wb_valid;
  logic        wb_ready = 1'b1;
  logic [4:0]  wb_dest;
  logic [31:0] wb_data;
  logic        wb_illegal;
  logic        wb_timeout;
  logic        busy;

  int n_chk  = 0;
  int n_fail = 0;
  int mode   = 0;
  int wcnt   = 0;

  alu_dispatch_stage #(.START_CYCLES(2), .TIMEOUT_CYCLES(64)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_inst_num(in_inst_num), .in_const16_x(in_const16_x),
    .in_shift5(in_shift5), .in_rs(in_rs), .in_rt(in_rt),
    .in_dest(in_dest),
    .elem_reset(elem_reset), .elem_inst_num(elem_inst_num),
    .elem_const16_x(elem_const16_x), .elem_shift5(elem_shift5),
    .elem_rs(elem_rs), .elem_rt(elem_rt),
    .elem_completed(elem_completed), .elem_out(elem_out),
    .wb_valid(wb_valid), .wb_ready(wb_ready),
    .wb_dest(wb_dest), .wb_data(wb_data),
    .wb_illegal(wb_illegal), .wb_timeout(wb_timeout),
    .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] alu_f(
    input logic [5:0] op, input logic [31:0] rs, input logic [31:0] rt,
    input logic [31:0] c, input logic [4:0] sh);
    case (op)
      6'd8:    return rs + rt;
      6'd10:   return rs - rt;
      6'd13:   return rs * rt;
      6'd16:   return rs << sh;
      6'd20:   return rs & rt;
      6'd23:   return rs | c;
      default: return 32'd0;
    endcase
  endfunction

  // Element model: wcnt = WAIT cycles already elapsed before the current one.
  always @(posedge clk) begin
    if (elem_reset) wcnt <= 0;
    else            wcnt <= wcnt + 1;
  end

  assign elem_out = alu_f(elem_inst_num, elem_rs, elem_rt,
                          elem_const16_x, elem_shift5);
  assign elem_completed = !elem_reset &&
                          ((mode == 0) ? (wcnt >= 2) :
                           (mode == 2) ? (wcnt == 63) : 1'b0);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_accept(input logic [5:0] op, input logic [31:0] rs,
                           input logic [31:0] rt, input logic [31:0] c,
                           input logic [4:0] sh, input logic [4:0] d);
    in_inst_num  = op;
    in_rs        = rs;
    in_rt        = rt;
    in_const16_x = c;
    in_shift5    = sh;
    in_dest      = d;
    in_valid     = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int cyc);
    cyc = 1;
    while (!wb_valid && cyc < 200) begin
      tick();
      cyc++;
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    int n_acc;
    int n_res;
    bit acc_now;
    logic [31:0] res [2];
    logic [4:0]  dst [2];
    int acc_cyc [3];

    #1 reset = 1'b1;
    #2;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_elem_reset", elem_reset, 1);
    chk("rst_wb_valid", wb_valid, 0);
    chk("rst_wb_data", wb_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_elem_rs", elem_rs, 0);
    tick();
    reset = 1'b0;
    tick();

    // ADD 17+255
    mode = 0;
    do_accept(6'd8, 32'd17, 32'd255, 32'd0, 5'd0, 5'd3);
    chk("add_c1_elem_reset", elem_reset, 1);
    chk("add_c1_busy", busy, 1);
    chk("add_elem_rs", elem_rs, 32'd17);
    tick();
    chk("add_c2_elem_reset", elem_reset, 1);
    tick();
    chk("add_c3_elem_reset", elem_reset, 0);
    tick();
    tick();
    chk("add_c5_wb_valid", wb_valid, 0);
    tick();
    chk("add_c6_wb_valid", wb_valid, 1);
    chk("add_wb_data", wb_data, 32'd272);
    chk("add_wb_dest", wb_dest, 32'd3);
    tick();
    chk("add_c7_wb_valid", wb_valid, 0);
    chk("add_c7_in_ready", in_ready, 1);

    // SUB with writeback stalled 5 cycles
    wb_ready = 1'b0;
    do_accept(6'd10, 32'ha9876543, 32'h98765432, 32'd0, 5'd0, 5'd4);
    wait_valid(cyc);
    chk("sub_latency", cyc, 6);
    for (int i = 0; i < 5; i++) begin
      chk("sub_hold_valid", wb_valid, 1);
      chk("sub_hold_data", wb_data, 32'h11111111);
      chk("sub_hold_in_ready", in_ready, 0);
      tick();
    end
    wb_ready = 1'b1;
    chk("sub_last_valid", wb_valid, 1);
    tick();
    chk("sub_idle_in_ready", in_ready, 1);
    chk("sub_idle_busy", busy, 0);

    // element never completes
    mode = 1;
    do_accept(6'd8, 32'd1, 32'd1, 32'd0, 5'd0, 5'd5);
    wait_valid(cyc);
    chk("tmo_latency", cyc, 67);
    chk("tmo_flag", wb_timeout, 1);
    chk("tmo_data", wb_data, 0);
    chk("tmo_illegal", wb_illegal, 0);
    tick();
    chk("tmo_cleared", wb_timeout, 0);

    // completion on the 64th WAIT cycle wins over timeout
    mode = 2;
    do_accept(6'd8, 32'd100, 32'd23, 32'd0, 5'd0, 5'd6);
    wait_valid(cyc);
    chk("late_latency", cyc, 67);
    chk("late_timeout", wb_timeout, 0);
    chk("late_data", wb_data, 32'd123);
    tick();

    // illegal opcode 19
    mode = 0;
    do_accept(6'd19, 32'd5, 32'd6, 32'd0, 5'd0, 5'd8);
    chk("ill_valid", wb_valid, 1);
    chk("ill_flag", wb_illegal, 1);
    chk("ill_data", wb_data, 0);
    chk("ill_dest", wb_dest, 32'd8);
    chk("ill_c1_elem_reset", elem_reset, 1);
    tick();
    chk("ill_c2_elem_reset", elem_reset, 1);
    chk("ill_cleared", wb_illegal, 0);
    chk("ill_idle", in_ready, 1);

    // reset mid-WAIT during MULT
    do_accept(6'd13, 32'hdab, 32'heae, 32'd0, 5'd0, 5'd9);
    tick();
    tick();
    chk("mul_in_wait", elem_reset, 0);
    reset = 1'b1;
    #1;
    chk("ar_in_ready", in_ready, 1);
    chk("ar_elem_reset", elem_reset, 1);
    chk("ar_elem_rs", elem_rs, 0);
    chk("ar_elem_op", elem_inst_num, 0);
    chk("ar_wb_valid", wb_valid, 0);
    chk("ar_wb_dest", wb_dest, 0);
    chk("ar_busy", busy, 0);
    tick();
    reset = 1'b0;
    tick();
    tick();
    tick();
    chk("ar_no_result", wb_valid, 0);

    // SLL after reset
    do_accept(6'd16, 32'hc50fa357, 32'd0, 32'd0, 5'd15, 5'd10);
    wait_valid(cyc);
    chk("sll_latency", cyc, 6);
    chk("sll_data", wb_data, 32'hd1ab8000);
    tick();

    // back-to-back AND then ORI, in_valid held
    in_inst_num  = 6'd20;
    in_rs        = 32'd3;
    in_rt        = 32'd5;
    in_const16_x = 32'd5;
    in_dest      = 5'd7;
    in_valid     = 1'b1;
    n_acc = 0;
    n_res = 0;
    cyc   = 0;
    while (n_res < 2 && cyc < 60) begin
      if (wb_valid) begin
        res[n_res] = wb_data;
        dst[n_res] = wb_dest;
        n_res++;
      end
      acc_now = in_valid && in_ready;
      tick();
      cyc++;
      if (acc_now) begin
        acc_cyc[n_acc] = cyc;
        n_acc++;
        if (n_acc == 1) begin
          in_inst_num = 6'd23;
          in_dest     = 5'd9;
        end else begin
          in_valid = 1'b0;
        end
      end
    end
    in_valid = 1'b0;
    chk("b2b_count", n_res, 2);
    chk("b2b_acc", n_acc, 2);
    chk("b2b_spacing", acc_cyc[1] - acc_cyc[0], 7);
    chk("b2b_res0", res[0], 32'd1);
    chk("b2b_dst0", dst[0], 32'd7);
    chk("b2b_res1", res[1], 32'd7);
    chk("b2b_dst1", dst[1], 32'd9);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
